// File: rtl/conv2d_bn_relu6_param_engine.sv
`default_nettype none
// ============================================================================
// conv2d_bn_relu6_param_engine
// Parametrised conv2d + batchnorm + ReLU6 layer on one sequential MAC datapath.
// Revision: 1.0
// ============================================================================
module conv2d_bn_relu6_param_engine #(
    parameter int IM_W      = 32,
    parameter int IM_H      = 32,
    parameter int NUM_CH    = 3,
    parameter int NUM_FILT  = 32,
    parameter int KSIZE     = 3,
    parameter int OUT_BITS  = 4,
    parameter int ACC_SHIFT = 7,
    parameter int RELU_MAX  = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stride2,
    input  logic                pad_same,
    output logic                busy,
    output logic                done,
    input  logic                ld_en,
    input  logic [1:0]          ld_sel,
    input  logic [31:0]         ld_addr,
    input  logic [15:0]         ld_data,
    input  logic [31:0]         rd_addr,
    output logic [OUT_BITS-1:0] rd_data,
    output logic                rd_valid
);

    localparam int c_kk     = KSIZE * KSIZE;
    localparam int c_nk     = NUM_CH * c_kk;
    localparam int c_pad    = (KSIZE - 1) / 2;
    localparam int c_img_n  = NUM_CH * IM_H * IM_W;
    localparam int c_w_n    = NUM_FILT * c_nk;
    localparam int c_out_n  = NUM_FILT * IM_H * IM_W;
    localparam int c_img_aw = (c_img_n > 1) ? $clog2(c_img_n) : 1;
    localparam int c_w_aw   = (c_w_n > 1) ? $clog2(c_w_n) : 1;
    localparam int c_f_aw   = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
    localparam int c_out_aw = (c_out_n > 1) ? $clog2(c_out_n) : 1;

    localparam logic [15:0] c_oh_s1 = 16'(IM_H);
    localparam logic [15:0] c_oh_s2 = 16'((IM_H + 1) / 2);
    localparam logic [15:0] c_oh_v1 = 16'(IM_H - KSIZE + 1);
    localparam logic [15:0] c_oh_v2 = 16'((IM_H - KSIZE) / 2 + 1);
    localparam logic [15:0] c_ow_s1 = 16'(IM_W);
    localparam logic [15:0] c_ow_s2 = 16'((IM_W + 1) / 2);
    localparam logic [15:0] c_ow_v1 = 16'(IM_W - KSIZE + 1);
    localparam logic [15:0] c_ow_v2 = 16'((IM_W - KSIZE) / 2 + 1);
    localparam logic signed [16:0] c_imh_s = 17'(IM_H);
    localparam logic signed [16:0] c_imw_s = 17'(IM_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   stride2_q, stride2_d, pad_same_q, pad_same_d;
    logic   busy_q, busy_d, done_q, done_d;
    logic [15:0] f_q, f_d, oy_q, oy_d, ox_q, ox_d;
    logic [15:0] ch_q, ch_d, ky_q, ky_d, kx_q, kx_d;
    logic signed [31:0] acc_q, acc_d;
    logic [OUT_BITS-1:0] rd_data_q, rd_data_d;
    logic   rd_valid_q, rd_valid_d;

    logic [7:0]          img_mem_q  [c_img_n];
    logic [7:0]          w_mem_q    [c_w_n];
    logic [7:0]          bias_mem_q [NUM_FILT];
    logic [15:0]         bn_mem_q   [NUM_FILT];
    logic [OUT_BITS-1:0] out_mem_q  [c_out_n];

    logic [15:0]        w_oh, w_ow, w_ybase, w_xbase;
    logic [31:0]        w_pix_n, w_img_idx, w_w_idx, w_out_idx;
    logic signed [16:0] w_pad, w_iy, w_ix;
    logic               w_tap_ok, w_last_tap, w_last_ox, w_last_oy, w_last_f;
    logic [7:0]         w_img_px, w_wt, w_bias;
    logic [15:0]        w_bn_pair;
    logic signed [15:0] w_prod;
    logic signed [31:0] w_prod_ext, w_acc_full, w_acc_sh, w_acc_c;
    logic signed [31:0] w_scale, w_shift, w_bn, w_q;
    logic [OUT_BITS-1:0] w_q_st;
    logic               w_out_we, w_ld_ok;

    // Output geometry follows the modes captured at start.
    always_comb begin
        if (pad_same_q) begin
            w_oh = stride2_q ? c_oh_s2 : c_oh_s1;
            w_ow = stride2_q ? c_ow_s2 : c_ow_s1;
        end else begin
            w_oh = stride2_q ? c_oh_v2 : c_oh_v1;
            w_ow = stride2_q ? c_ow_v2 : c_ow_v1;
        end
        w_pix_n = 32'(NUM_FILT) * {16'd0, w_oh} * {16'd0, w_ow};
    end

    // Tap address generation: input coordinate = o*s + k - pad.
    always_comb begin
        w_ybase  = stride2_q ? {oy_q[14:0], 1'b0} : oy_q;
        w_xbase  = stride2_q ? {ox_q[14:0], 1'b0} : ox_q;
        w_pad    = pad_same_q ? 17'(c_pad) : 17'sd0;
        w_iy     = $signed({1'b0, w_ybase + ky_q}) - w_pad;
        w_ix     = $signed({1'b0, w_xbase + kx_q}) - w_pad;
        w_tap_ok = (w_iy >= 17'sd0) && (w_iy < c_imh_s) &&
                   (w_ix >= 17'sd0) && (w_ix < c_imw_s);
        w_img_idx = '0;
        if (w_tap_ok) begin
            w_img_idx = 32'(ch_q) * 32'(IM_H * IM_W) +
                        32'(w_iy[15:0]) * 32'(IM_W) + 32'(w_ix[15:0]);
        end
        w_w_idx = 32'(f_q) * 32'(c_nk) + 32'(ch_q) * 32'(c_kk) +
                  32'(ky_q) * 32'(KSIZE) + 32'(kx_q);
        w_img_px = (w_tap_ok && (w_img_idx < 32'(c_img_n))) ?
                   img_mem_q[w_img_idx[c_img_aw-1:0]] : 8'd0;
        w_wt     = (w_w_idx < 32'(c_w_n)) ? w_mem_q[w_w_idx[c_w_aw-1:0]] : 8'd0;
        w_prod     = $signed(w_img_px) * $signed(w_wt);
        w_prod_ext = {{16{w_prod[15]}}, w_prod};
    end

    // Post-accumulation: bias, shift/clamp to int8, BN, requantise and ReLU6.
    always_comb begin
        w_bias     = bias_mem_q[f_q[c_f_aw-1:0]];
        w_bn_pair  = bn_mem_q[f_q[c_f_aw-1:0]];
        w_acc_full = acc_q + {{24{w_bias[7]}}, w_bias};
        w_acc_sh   = w_acc_full >>> ACC_SHIFT;
        if (w_acc_sh > 32'sd127) begin
            w_acc_c = 32'sd127;
        end else if (w_acc_sh < -32'sd128) begin
            w_acc_c = -32'sd128;
        end else begin
            w_acc_c = w_acc_sh;
        end
        w_scale = {{24{w_bn_pair[15]}}, w_bn_pair[15:8]};
        w_shift = {{24{w_bn_pair[7]}}, w_bn_pair[7:0]};
        w_bn    = (w_acc_c * w_scale + w_shift) >>> 7;
        w_q     = (w_bn + 32'sd128) >>> 5;
        if (w_q < 32'sd0) begin
            w_q_st = '0;
        end else if (w_q > RELU_MAX) begin
            w_q_st = OUT_BITS'(RELU_MAX);
        end else begin
            w_q_st = w_q[OUT_BITS-1:0];
        end
        w_out_idx = 32'(f_q) * {16'd0, w_oh} * {16'd0, w_ow} +
                    {16'd0, oy_q} * {16'd0, w_ow} + {16'd0, ox_q};
    end

    assign w_last_tap = (kx_q == 16'(KSIZE - 1)) && (ky_q == 16'(KSIZE - 1)) &&
                        (ch_q == 16'(NUM_CH - 1));
    assign w_last_ox  = (ox_q == w_ow - 16'd1);
    assign w_last_oy  = (oy_q == w_oh - 16'd1);
    assign w_last_f   = (f_q == 16'(NUM_FILT - 1));

    always_comb begin
        state_d    = state_q;
        stride2_d  = stride2_q;
        pad_same_d = pad_same_q;
        f_d  = f_q;
        oy_d = oy_q;
        ox_d = ox_q;
        ch_d = ch_q;
        ky_d = ky_q;
        kx_d = kx_q;
        acc_d    = acc_q;
        w_out_we = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stride2_d  = stride2;
                    pad_same_d = pad_same;
                    f_d  = '0;
                    oy_d = '0;
                    ox_d = '0;
                    ch_d = '0;
                    ky_d = '0;
                    kx_d = '0;
                    acc_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + w_prod_ext;
                if (kx_q == 16'(KSIZE - 1)) begin
                    kx_d = '0;
                    if (ky_q == 16'(KSIZE - 1)) begin
                        ky_d = '0;
                        ch_d = (ch_q == 16'(NUM_CH - 1)) ? 16'd0 : ch_q + 16'd1;
                    end else begin
                        ky_d = ky_q + 16'd1;
                    end
                end else begin
                    kx_d = kx_q + 16'd1;
                end
                if (w_last_tap) begin
                    state_d = S_POST;
                end
            end
            S_POST: begin
                w_out_we = 1'b1;
                acc_d    = '0;
                state_d  = S_MAC;
                if (w_last_ox) begin
                    ox_d = '0;
                    if (w_last_oy) begin
                        oy_d = '0;
                        if (w_last_f) begin
                            f_d     = '0;
                            state_d = S_DONE;
                        end else begin
                            f_d = f_q + 16'd1;
                        end
                    end else begin
                        oy_d = oy_q + 16'd1;
                    end
                end else begin
                    ox_d = ox_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_q == S_DONE);
        rd_valid_d = (rd_addr < w_pix_n);
        rd_data_d  = rd_valid_d ? out_mem_q[rd_addr[c_out_aw-1:0]] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            stride2_q  <= 1'b0;
            pad_same_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            f_q  <= '0;
            oy_q <= '0;
            ox_q <= '0;
            ch_q <= '0;
            ky_q <= '0;
            kx_q <= '0;
            acc_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            stride2_q  <= stride2_d;
            pad_same_q <= pad_same_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            f_q  <= f_d;
            oy_q <= oy_d;
            ox_q <= ox_d;
            ch_q <= ch_d;
            ky_q <= ky_d;
            kx_q <= kx_d;
            acc_q      <= acc_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Memories hold their contents across reset.
    assign w_ld_ok = ld_en && !busy_q;

    always_ff @(posedge clk) begin
        if (w_ld_ok) begin
            case (ld_sel)
                2'd0: if (ld_addr < 32'(c_img_n)) img_mem_q[ld_addr[c_img_aw-1:0]] <= ld_data[7:0];
                2'd1: if (ld_addr < 32'(c_w_n)) w_mem_q[ld_addr[c_w_aw-1:0]] <= ld_data[7:0];
                2'd2: if (ld_addr < 32'(NUM_FILT)) bias_mem_q[ld_addr[c_f_aw-1:0]] <= ld_data[7:0];
                default: if (ld_addr < 32'(NUM_FILT)) bn_mem_q[ld_addr[c_f_aw-1:0]] <= ld_data;
            endcase
        end
        if (w_out_we && (w_out_idx < 32'(c_out_n))) begin
            out_mem_q[w_out_idx[c_out_aw-1:0]] <= w_q_st;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_bn_relu6_param_engine.sv
`default_nettype none
// ============================================================================
// tb_conv2d_bn_relu6_param_engine
// Directed bench for the 4x4x1, 2-filter, 3x3 configuration.
// Revision: 1.0
// ============================================================================
module tb_conv2d_bn_relu6_param_engine;

    localparam int c_w  = 4;
    localparam int c_h  = 4;
    localparam int c_nf = 2;
    localparam int c_k  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stride2 = 1'b0;
    logic        pad_same = 1'b0;
    logic        ld_en = 1'b0;
    logic [1:0]  ld_sel = 2'd0;
    logic [31:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [31:0] rd_addr = '0;
    logic        busy, done, rd_valid;
    logic [3:0]  rd_data;

    int errors = 0;
    int checks = 0;

    conv2d_bn_relu6_param_engine #(
        .IM_W(c_w), .IM_H(c_h), .NUM_CH(1), .NUM_FILT(c_nf), .KSIZE(c_k),
        .OUT_BITS(4), .ACC_SHIFT(7), .RELU_MAX(6)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .stride2(stride2),
        .pad_same(pad_same), .busy(busy), .done(done), .ld_en(ld_en),
        .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [1:0] sel, input int addr, input logic [15:0] data);
        @(negedge clk);
        ld_en = 1'b1; ld_sel = sel; ld_addr = 32'(addr); ld_data = data;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic fill_img(input logic [7:0] v);
        for (int i = 0; i < c_w * c_h; i++) load(2'd0, i, {8'd0, v});
    endtask

    task automatic fill_w(input logic [7:0] v);
        for (int i = 0; i < c_nf * c_k * c_k; i++) load(2'd1, i, {8'd0, v});
    endtask

    task automatic set_post();
        for (int f = 0; f < c_nf; f++) begin
            load(2'd2, f, 16'h0000);
            load(2'd3, f, 16'h7F00);
        end
    endtask

    task automatic rd_chk(input string tag, input int idx, input int exp_d, input int exp_v);
        @(negedge clk);
        rd_addr = 32'(idx);
        @(posedge clk); #1;
        check({tag, " data"}, 32'(rd_data), 32'(exp_d));
        check({tag, " valid"}, 32'(rd_valid), 32'(exp_v));
    endtask

    // Runs one layer; optionally injects start+ld_en at cycle inject_at.
    task automatic run_conv(input logic s2, input logic same, input int exp_lat,
                            input string tag, input int inject_at);
        int cyc;
        int extra;
        @(negedge clk);
        stride2 = s2; pad_same = same; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check({tag, " busy"}, 32'(busy), 32'd1);
        while (!done && cyc < 3000) begin
            if (cyc == inject_at) begin
                start = 1'b1; ld_en = 1'b1; ld_sel = 2'd1; ld_addr = '0;
                ld_data = 16'h0080; stride2 = ~s2; pad_same = ~same;
            end
            @(posedge clk); #1;
            start = 1'b0; ld_en = 1'b0;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " busy at done"}, 32'(busy), 32'd0);
        extra = 0;
        repeat (400) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check({tag, " extra done"}, 32'(extra), 32'd0);
    endtask

    // Same/stride-1 map: corners use 4 taps, everything else at least 6.
    task automatic chk_map(input string tag, input int corner, input int other);
        int e;
        for (int f = 0; f < c_nf; f++)
            for (int y = 0; y < c_h; y++)
                for (int x = 0; x < c_w; x++) begin
                    e = ((y == 0 || y == c_h - 1) && (x == 0 || x == c_w - 1)) ? corner : other;
                    rd_chk($sformatf("%s f%0d y%0d x%0d", tag, f, y, x),
                           f * 16 + y * 4 + x, e, 1);
                end
    endtask

    initial begin
        int cyc;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Saturating case: 127*127 everywhere.
        fill_img(8'd127);
        fill_w(8'd127);
        set_post();
        run_conv(1'b0, 1'b1, 322, "t1", -1);
        chk_map("t1", 6, 6);

        fill_img(8'd0);
        run_conv(1'b0, 1'b1, 322, "t2a", -1);
        rd_chk("t2a idx0", 0, 4, 1);
        rd_chk("t2a idx21", 21, 4, 1);
        rd_chk("t2a idx31", 31, 4, 1);

        fill_img(8'd127);
        fill_w(8'h80);
        run_conv(1'b0, 1'b1, 322, "t2b", -1);
        rd_chk("t2b idx0", 0, 0, 1);
        rd_chk("t2b idx5", 5, 0, 1);
        rd_chk("t2b idx30", 30, 0, 1);

        // Weight 16: corner sum 8128 -> 5; edge/interior -> 6.
        fill_w(8'd16);
        run_conv(1'b0, 1'b1, 322, "t3", -1);
        chk_map("t3", 5, 6);

        run_conv(1'b0, 1'b0, 82, "t4 v1", -1);
        rd_chk("t4 v1 idx0", 0, 6, 1);
        rd_chk("t4 v1 idx7", 7, 6, 1);
        rd_chk("t4 v1 idx8", 8, 0, 0);

        run_conv(1'b1, 1'b1, 82, "t4 s2", -1);
        rd_chk("t4 s2 idx0", 0, 5, 1);
        rd_chk("t4 s2 idx1", 1, 6, 1);
        rd_chk("t4 s2 idx3", 3, 6, 1);
        rd_chk("t4 s2 idx4", 4, 5, 1);
        rd_chk("t4 s2 idx7", 7, 6, 1);
        rd_chk("t4 s2 idx8", 8, 0, 0);

        run_conv(1'b1, 1'b0, 22, "t4 v2", -1);
        rd_chk("t4 v2 idx0", 0, 6, 1);
        rd_chk("t4 v2 idx1", 1, 6, 1);
        rd_chk("t4 v2 idx2", 2, 0, 0);

        // Start + load while busy must both be ignored.
        run_conv(1'b0, 1'b1, 322, "t5", 100);
        chk_map("t5", 5, 6);

        // Async reset at cycle 50, then a clean run with new weights.
        @(negedge clk);
        stride2 = 1'b0; pad_same = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        reset = 1'b1;
        #1;
        check("t6 busy on reset", 32'(busy), 32'd0);
        check("t6 done on reset", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        repeat (350) begin
            @(posedge clk); #1;
            if (done || busy) cyc++;
        end
        check("t6 idle after reset", 32'(cyc), 32'd0);
        fill_w(8'd127);
        run_conv(1'b0, 1'b1, 322, "t6", -1);
        chk_map("t6", 6, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv2d_bn_relu6_param_engine.md
Name: conv2d_bn_relu6_param_engine

Overview:
- Parametrised successor to the fixed 32x32x3, 32-filter conv2d + batchnorm + ReLU6 layer.
- Generalises image size, channel count, filter count, kernel size and output width.
- Adds run-time stride (1/2) and padding (same/valid) modes, a host load port for the image, weight, bias and BN memories, and a registered readback port.
- Uses one sequential MAC datapath. Sits between the RISC-V SoC bus bridge and the next CNN layer.

Parameters:
IM_W, 32, input width in pixels
IM_H, 32, input height in pixels
NUM_CH, 3, input channels
NUM_FILT, 32, output filters
KSIZE, 3, kernel side (odd, >=1)
OUT_BITS, 4, stored width per output activation
ACC_SHIFT, 7, accumulator right-shift before the int8 clamp
RELU_MAX, 6, upper clamp of the activation

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  run request; sampled only in IDLE
stride2  in  1  latched at start; 0 = stride 1, 1 = stride 2
pad_same  in  1  latched at start; 1 = zero-pad (KSIZE-1)/2 on every side, 0 = valid
busy  out  1  run in progress
done  out  1  one-cycle completion pulse
ld_en  in  1  load strobe; ignored while busy
ld_sel  in  2  target: 0 = image, 1 = weight, 2 = bias, 3 = BN pair
ld_addr  in  32  word index within the target (image: ch*IM_H*IM_W+y*IM_W+x; weight: f*NUM_CH*K*K+ch*K*K+ky*K+kx)
ld_data  in  16  [7:0] = int8 value; for the BN pair, [15:8] = scale and [7:0] = shift
rd_addr  in  32  output index f*OH*OW+oy*OW+ox
rd_data  out  OUT_BITS  output activation
rd_valid  out  1  rd_data corresponds to the rd_addr of the previous cycle

Behaviour:
- Reset values: busy=0, done=0, rd_data=0, rd_valid=0; state=IDLE; all counters 0.
- Memory contents are not cleared by reset.
- Output dimensions:
  - same padding: OH = ceil(IM_H/s), OW = ceil(IM_W/s).
  - valid padding: OH = (IM_H-KSIZE)/s+1, OW = (IM_W-KSIZE)/s+1.
- State machine:
  - IDLE: on start, latch the modes, clear the counters, set busy=1 next cycle, go to MAC.
  - MAC: one product per cycle over ch, ky, kx (NUM_CH*K*K cycles).
    - Input coordinate = o*s + k - pad.
    - Out-of-range taps contribute 0.
    - After the last tap, go to POST.
  - POST: one cycle. Compute the result, write out_mem, then advance ox, then oy, then f. After the last pixel of the last filter go to DONE, otherwise return to MAC.
  - DONE: one cycle. done=1, busy=0, go to IDLE.
- Latency: start to done = 2 + NUM_FILT*OH*OW*(NUM_CH*K*K+1) cycles.
- POST arithmetic (signed):
  - acc (32 bit) = sum(img*w) + bias.
  - acc >>>= ACC_SHIFT, then clamp to [-128,127].
  - bn = (acc*scale + shift) >>> 7.
  - q = (bn+128) >>> 5, then clamp to [0,RELU_MAX].
  - Store q[OUT_BITS-1:0].
- Readback:
  - rd_data is registered with 1-cycle latency.
  - rd_valid=1 the cycle after any read whose index is < NUM_FILT*OH*OW.
  - An out-of-range index returns rd_data=0 with rd_valid=0.
  - Reads are allowed while busy and return current contents.
- Load: takes effect at the clock edge. An out-of-range ld_addr is dropped.
- start while busy: ignored; the modes do not change.
- start and ld_en in the same IDLE cycle: the load is applied, and the run sees the new value.
- Reset mid-run: next state IDLE, busy=0, no done pulse, out_mem partially written.

Test Plan:
All scenarios use IM_W=IM_H=4, NUM_CH=1, NUM_FILT=2, K=3.
1. Image all 127, weights all 127, bias 0, scale 127, shift 0, stride 1, same padding -> all 32 outputs = 6; done exactly 322 cycles after start.
2. Image all 0 -> every output = 4. Image 127 with weights -128 -> every output = 0.
3. Image 127, weights 16, scale 127, stride 1, same padding -> corner outputs = 5 (zero-pad taps contribute nothing), edge and interior outputs = 6.
4. Mode sweep:
   - valid, stride 1 -> rd_valid for indices 0..7 only, index 8 gives rd_valid=0, done at 82 cycles.
   - same, stride 2 -> 8 outputs.
   - valid, stride 2 -> 2 outputs, done at 22 cycles.
5. Assert start and ld_en mid-run -> no restart, memories unchanged, single done pulse.
6. Assert reset at cycle 50 of a run -> busy=0 and done=0 at once. A following start completes normally with correct results.
